pipelined_control_unit: RTL

- Parametrised second-generation control unit for the 5-stage RV32I pipeline.
- Decodes the instruction fields in the Decode stage and carries the control bundle through its own ID/EX, EX/MEM and MEM/WB control registers.
- Resolves the full branch set (beq/bne/blt/bge/bltu/bgeu), jal and jalr in Execute using ALU flags.
- Adds lui/auipc decode, a 4-bit ALU control, load/store width passthrough, an Execute stall, and illegal-opcode flagging.

---
 rtl/pipelined_control_unit.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit
//   Control unit for a 5-stage RV32I pipeline. Decodes op/funct3/funct7b5 in
//   Decode, carries the control bundle through its own ID/EX, EX/MEM and
//   MEM/WB registers, and resolves branches/jumps in Execute from ALU flags.
//
// Ports
//   clk, reset (async, active-low)
//   op, funct3, funct7b5            : Decode-stage instruction fields
//   ZeroE, SignE, OverflowE, CarryE : Execute ALU flags
//   StallE, FlushE                  : ID/EX hold / clear
//   ImmSrcD, IllegalD               : combinational Decode outputs
//   ALUControlE, ALUSrcAE, ALUSrcBE, PCSrcE, PCJalSrcE, ResultSrcEb0, IllegalE
//   MemWriteM, Funct3M, RegWriteM   : Memory-stage controls
//   RegWriteW, ResultSrcW           : Writeback-stage controls
module pipelined_control_unit #(
    parameter int ALUC_W      = 4,
    parameter bit BRANCH_FULL = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [6:0]        op,
    input  logic [2:0]        funct3,
    input  logic              funct7b5,
    input  logic              ZeroE,
    input  logic              SignE,
    input  logic              OverflowE,
    input  logic              CarryE,
    input  logic              StallE,
    input  logic              FlushE,
    output logic [2:0]        ImmSrcD,
    output logic              IllegalD,
    output logic [ALUC_W-1:0] ALUControlE,
    output logic              ALUSrcAE,
    output logic [1:0]        ALUSrcBE,
    output logic              PCSrcE,
    output logic              PCJalSrcE,
    output logic              ResultSrcEb0,
    output logic              IllegalE,
    output logic              MemWriteM,
    output logic [2:0]        Funct3M,
    output logic              RegWriteM,
    output logic              RegWriteW,
    output logic [1:0]        ResultSrcW
);

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;
    localparam logic [3:0] ALU_PASSB = 4'b1010;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic       jal_src;
        logic [3:0] alu_ctl;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] funct3;
        logic       illegal;
    } ctl_t;

    ctl_t       ctl_d;
    ctl_t       ctl_e;
    logic       reg_write_m;
    logic [1:0] result_src_m;
    logic       mem_write_m;
    logic [2:0] funct3_m;
    logic       reg_write_w;
    logic [1:0] result_src_w;
    logic       taken_e;

    // alt selects sub (funct3 000) or sra (funct3 101); callers mask it for I-ALU.
    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  alu_op = ALU_SLL;
            3'b010:  alu_op = ALU_SLT;
            3'b011:  alu_op = ALU_SLTU;
            3'b100:  alu_op = ALU_XOR;
            3'b101:  alu_op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_op = ALU_OR;
            default: alu_op = ALU_AND;
        endcase
    endfunction

    always_comb begin
        ctl_d        = '0;
        ctl_d.funct3 = funct3;
        ImmSrcD      = 3'b000;
        case (op)
            7'b0000011: begin
                ctl_d.reg_write  = 1'b1;
                ctl_d.alu_src_b  = 2'b01;
                ctl_d.result_src = 2'b01;
                ctl_d.alu_ctl    = ALU_ADD;
            end
            7'b0100011: begin
                ctl_d.mem_write = 1'b1;
                ctl_d.alu_src_b = 2'b01;
                ctl_d.alu_ctl   = ALU_ADD;
                ImmSrcD         = 3'b001;
            end
            7'b0110011: begin
                ctl_d.reg_write = 1'b1;
                ctl_d.alu_ctl   = alu_op(funct3, funct7b5);
            end
            7'b0010011: begin
                ctl_d.reg_write = 1'b1;
                ctl_d.alu_src_b = 2'b01;
                ctl_d.alu_ctl   = alu_op(funct3, funct7b5 & (funct3 == 3'b101));
            end
            7'b1100011: begin
                ctl_d.branch  = 1'b1;
                ctl_d.alu_ctl = ALU_SUB;
                ImmSrcD       = 3'b010;
                if (BRANCH_FULL)
                    ctl_d.illegal = (funct3[2:1] == 2'b01);
                else
                    ctl_d.illegal = (funct3[2:1] != 2'b00);
            end
            7'b1101111: begin
                ctl_d.reg_write  = 1'b1;
                ctl_d.jump       = 1'b1;
                ctl_d.result_src = 2'b10;
                ImmSrcD          = 3'b011;
            end
            7'b1100111: begin
                ctl_d.reg_write  = 1'b1;
                ctl_d.jump       = 1'b1;
                ctl_d.jal_src    = 1'b1;
                ctl_d.alu_src_b  = 2'b01;
                ctl_d.alu_ctl    = ALU_ADD;
                ctl_d.result_src = 2'b10;
                ctl_d.illegal    = (funct3 != 3'b000);
            end
            7'b0110111: begin
                ctl_d.reg_write = 1'b1;
                ctl_d.alu_src_b = 2'b01;
                ctl_d.alu_ctl   = ALU_PASSB;
                ImmSrcD         = 3'b100;
            end
            7'b0010111: begin
                ctl_d.reg_write = 1'b1;
                ctl_d.alu_src_a = 1'b1;
                ctl_d.alu_src_b = 2'b01;
                ctl_d.alu_ctl   = ALU_ADD;
                ImmSrcD         = 3'b100;
            end
            default: ctl_d.illegal = 1'b1;
        endcase
        // An illegal instruction travels down the pipe as a NOP.
        if (ctl_d.illegal) begin
            ctl_d.reg_write = 1'b0;
            ctl_d.mem_write = 1'b0;
            ctl_d.branch    = 1'b0;
            ctl_d.jump      = 1'b0;
        end
    end

    assign IllegalD = ctl_d.illegal;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            ctl_e <= '0;
        else if (FlushE)
            ctl_e <= '0;
        else if (!StallE)
            ctl_e <= ctl_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reg_write_m  <= 1'b0;
            result_src_m <= 2'b00;
            mem_write_m  <= 1'b0;
            funct3_m     <= 3'b000;
            reg_write_w  <= 1'b0;
            result_src_w <= 2'b00;
        end else begin
            reg_write_m  <= ctl_e.reg_write;
            result_src_m <= ctl_e.result_src;
            mem_write_m  <= ctl_e.mem_write;
            funct3_m     <= ctl_e.funct3;
            reg_write_w  <= reg_write_m;
            result_src_w <= result_src_m;
        end
    end

    always_comb begin
        case (ctl_e.funct3)
            3'b000:  taken_e = ZeroE;
            3'b001:  taken_e = !ZeroE;
            3'b100:  taken_e = SignE ^ OverflowE;
            3'b101:  taken_e = !(SignE ^ OverflowE);
            3'b110:  taken_e = !CarryE;
            3'b111:  taken_e = CarryE;
            default: taken_e = 1'b0;
        endcase
    end

    always_comb begin
        ALUControlE      = '0;
        ALUControlE[3:0] = ctl_e.alu_ctl;
    end

    assign ALUSrcAE     = ctl_e.alu_src_a;
    assign ALUSrcBE     = ctl_e.alu_src_b;
    assign PCSrcE       = (ctl_e.branch & taken_e) | ctl_e.jump;
    assign PCJalSrcE    = ctl_e.jal_src;
    assign ResultSrcEb0 = ctl_e.result_src[0];
    assign IllegalE     = ctl_e.illegal;
    assign MemWriteM    = mem_write_m;
    assign Funct3M      = funct3_m;
    assign RegWriteM    = reg_write_m;
    assign RegWriteW    = reg_write_w;
    assign ResultSrcW   = result_src_w;

endmodule
